// File: rtl/lcd_show_char_engine.sv
// Glyph rasteriser: row fetch from a 1-cycle font ROM, one pixel per column. The first beat follows the request by 2 cycles.
// Each row takes 2+COLS cycles; a stalled beat holds x/y/colour until pix_ready; off-screen columns are skipped in one cycle.
module lcd_show_char_engine #(
  parameter logic [15:0] FG_COLOR = 16'h0000,
  parameter logic [15:0] BG_COLOR = 16'hFFFF,
  parameter int          LCD_W    = 240,
  parameter int          LCD_H    = 320
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size,
  output logic [10:0] rom_addr,
  output logic        rom_sel,
  input  logic [7:0]  rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        busy,
  output logic        show_char_done
);

  typedef enum logic [2:0] {IDLE, ADDR, LOAD, PIX, DONE} state_t;
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       size;
  } req_t;

  localparam logic [9:0] W_LIM = 10'(LCD_W);
  localparam logic [9:0] H_LIM = 10'(LCD_H);

  state_t      state, state_nxt;
  req_t        req, req_nxt;
  logic [3:0]  row, row_nxt;
  logic [2:0]  col, col_nxt;
  logic [6:0]  shreg, shreg_nxt;
  logic [10:0] rom_addr_nxt;
  logic        rom_sel_nxt, pix_valid_nxt, busy_nxt, done_nxt;
  logic [8:0]  pix_x_nxt, pix_y_nxt;
  logic [15:0] pix_color_nxt;

  logic [6:0]  idx;
  logic [10:0] base_addr;
  logic        last_col, last_row, adv;
  logic [2:0]  ld_col;
  logic        ld_bit, ld_in;
  logic [9:0]  ld_x, ld_y;

  // Out-of-table glyphs fall back to the space glyph at index 0.
  assign idx       = (ascii_num > 7'd94) ? 7'd0 : ascii_num;
  assign base_addr = en_size ? {idx, 4'b0000} : ({1'b0, idx, 3'b000} + {2'b00, idx, 2'b00});
  assign last_col  = req.size ? (col == 3'd7) : (col == 3'd5);
  assign last_row  = req.size ? (row == 4'd15) : (row == 4'd11);
  // A skipped (clipped) column never raises pix_valid, so it advances without a handshake.
  assign adv       = (state == PIX) && (pix_ready || !pix_valid);

  // Next pixel to present: column 0 straight from the ROM, later columns from the shift register.
  assign ld_col = (state == LOAD) ? 3'd0 : col + 3'd1;
  assign ld_bit = (state == LOAD) ? rom_data[7] : shreg[6];
  assign ld_x   = {1'b0, req.x} + {7'b0, ld_col};
  assign ld_y   = {1'b0, req.y} + {6'b0, row};
  assign ld_in  = (ld_x < W_LIM) && (ld_y < H_LIM);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (show_char_flag) state_nxt = ADDR;
      ADDR:    state_nxt = LOAD;
      LOAD:    state_nxt = PIX;
      PIX:     if (adv && last_col) state_nxt = last_row ? DONE : ADDR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_nxt       = req;
    row_nxt       = row;
    col_nxt       = col;
    shreg_nxt     = shreg;
    rom_addr_nxt  = rom_addr;
    rom_sel_nxt   = rom_sel;
    pix_valid_nxt = pix_valid;
    pix_x_nxt     = pix_x;
    pix_y_nxt     = pix_y;
    pix_color_nxt = pix_color;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (show_char_flag) begin
          req_nxt      = '{x: start_x, y: start_y, size: en_size};
          row_nxt      = 4'd0;
          rom_addr_nxt = base_addr;
          rom_sel_nxt  = en_size;
          busy_nxt     = 1'b1;
        end
      end
      LOAD: begin
        shreg_nxt     = rom_data[6:0];
        col_nxt       = 3'd0;
        pix_valid_nxt = ld_in;
        pix_x_nxt     = ld_x[8:0];
        pix_y_nxt     = ld_y[8:0];
        pix_color_nxt = ld_bit ? FG_COLOR : BG_COLOR;
      end
      PIX: begin
        if (adv) begin
          if (last_col) begin
            pix_valid_nxt = 1'b0;
            if (last_row) begin
              done_nxt = 1'b1;
              busy_nxt = 1'b0;
            end else begin
              // Glyph rows are stored consecutively, so the next row is just the next address.
              row_nxt      = row + 4'd1;
              rom_addr_nxt = rom_addr + 11'd1;
            end
          end else begin
            col_nxt       = ld_col;
            shreg_nxt     = {shreg[5:0], 1'b0};
            pix_valid_nxt = ld_in;
            pix_x_nxt     = ld_x[8:0];
            pix_y_nxt     = ld_y[8:0];
            pix_color_nxt = ld_bit ? FG_COLOR : BG_COLOR;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      req            <= '0;
      row            <= '0;
      col            <= '0;
      shreg          <= '0;
      rom_addr       <= '0;
      rom_sel        <= 1'b0;
      pix_valid      <= 1'b0;
      pix_x          <= '0;
      pix_y          <= '0;
      pix_color      <= '0;
      busy           <= 1'b0;
      show_char_done <= 1'b0;
    end else begin
      req            <= req_nxt;
      row            <= row_nxt;
      col            <= col_nxt;
      shreg          <= shreg_nxt;
      rom_addr       <= rom_addr_nxt;
      rom_sel        <= rom_sel_nxt;
      pix_valid      <= pix_valid_nxt;
      pix_x          <= pix_x_nxt;
      pix_y          <= pix_y_nxt;
      pix_color      <= pix_color_nxt;
      busy           <= busy_nxt;
      show_char_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_show_char_engine.sv
// Directed bench for lcd_show_char_engine: a table of character requests with hand-computed beat counts,
// done latency and ROM base, plus hand sequences for reentry, flag-at-done and mid-character reset.
module tb_lcd_show_char_engine;

  logic        sys_clk, sys_rst;
  logic        show_char_flag;
  logic [6:0]  ascii_num;
  logic [8:0]  start_x, start_y;
  logic        en_size;
  logic [10:0] rom_addr;
  logic        rom_sel;
  logic [7:0]  rom_data;
  logic        pix_valid, pix_ready;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_color;
  logic        busy, show_char_done;

  lcd_show_char_engine dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .show_char_flag(show_char_flag),
    .ascii_num(ascii_num), .start_x(start_x), .start_y(start_y), .en_size(en_size),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .busy(busy), .show_char_done(show_char_done)
  );

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
  } beat_t;

  typedef struct {
    int       asc;
    int       sx;
    int       sy;
    bit       size;
    bit       mode;      // 0: constant ROM pattern, 1: address-dependent data
    logic [7:0] pat;
    bit       rnd;       // pseudo-random pix_ready
    int       beats;
    int       done_cyc;  // -1: not checked
    int       base;
  } vec_t;

  vec_t  vecs[8];
  beat_t exp_q[$];
  beat_t got_q[$];

  int checks = 0, failures = 0;
  int edge_cnt = 0, req_edge = 0;
  int done_cnt = 0, done_cyc = 0, busy_err = 0, stall_err = 0;
  int rom_min = 2047, rom_max = 0;
  bit rom_mode = 0, rnd_ready = 0;
  logic [7:0] rom_pat = 8'h00;
  logic prev_v = 0, prev_r = 0;
  logic [8:0] prev_x = 0, prev_y = 0;
  logic [15:0] prev_c = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  // Synchronous font ROM, one cycle of read latency.
  always @(posedge sys_clk) rom_data <= rom_mode ? (rom_addr[7:0] ^ 8'h5A) : rom_pat;

  // Drives pix_ready for the coming edge, then records what that edge will accept.
  always @(negedge sys_clk) begin
    pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (prev_v && !prev_r &&
        (pix_valid !== 1'b1 || pix_x !== prev_x || pix_y !== prev_y || pix_color !== prev_c))
      stall_err++;
    prev_v = pix_valid; prev_r = pix_ready;
    prev_x = pix_x; prev_y = pix_y; prev_c = pix_color;
    if (pix_valid && pix_ready) got_q.push_back('{x: pix_x, y: pix_y, c: pix_color});
    if (show_char_done) begin
      done_cnt++;
      done_cyc = edge_cnt - req_edge;
      if (busy) busy_err++;
    end
    if (busy) begin
      if (int'(rom_addr) < rom_min) rom_min = int'(rom_addr);
      if (int'(rom_addr) > rom_max) rom_max = int'(rom_addr);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_char(input vec_t v);
    int rows, cols;
    rows = v.size ? 16 : 12;
    cols = v.size ? 8 : 6;
    exp_q.delete();
    got_q.delete();
    done_cnt = 0; busy_err = 0; stall_err = 0;
    rom_min = 2047; rom_max = 0;
    rom_mode = v.mode; rom_pat = v.pat; rnd_ready = v.rnd;
    for (int r = 0; r < rows; r++) begin
      logic [7:0] d;
      d = v.mode ? (8'(v.base + r) ^ 8'h5A) : v.pat;
      for (int c = 0; c < cols; c++) begin
        if (v.sx + c < 240 && v.sy + r < 320)
          exp_q.push_back('{x: 9'(v.sx + c), y: 9'(v.sy + r), c: (d[7-c] ? 16'h0000 : 16'hFFFF)});
      end
    end
    @(negedge sys_clk);
    ascii_num = 7'(v.asc); start_x = 9'(v.sx); start_y = 9'(v.sy); en_size = v.size;
    show_char_flag = 1'b1;
    req_edge = edge_cnt + 1;
    @(negedge sys_clk);
    show_char_flag = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("rom_base", rom_addr, v.base);
    chk("rom_sel", rom_sel, v.size);
  endtask

  task automatic finish_char(input vec_t v);
    int n, mism, first;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (4) @(negedge sys_clk);
    chk("done_seen", done_cnt != 0, 1);
    if (v.done_cyc >= 0) chk("done_cycle", done_cyc, v.done_cyc);
    chk("done_pulses", done_cnt, 1);
    chk("busy_low_with_done", busy_err, 0);
    chk("beat_count", got_q.size(), v.beats);
    mism = 0; first = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    chk("beat_data", mism, 0);
    if (first >= 0 && first < got_q.size())
      $display("  first bad beat %0d: got x=%0d y=%0d c=%h, want x=%0d y=%0d c=%h", first,
               got_q[first].x, got_q[first].y, got_q[first].c,
               exp_q[first].x, exp_q[first].y, exp_q[first].c);
    chk("stall_stable", stall_err, 0);
    chk("rom_min", rom_min, v.base);
    chk("rom_max", rom_max, v.base + (v.size ? 15 : 11));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{40, 128, 16, 1'b1, 1'b0, 8'hA5, 1'b0, 128, 160, 640};
    vecs[1] = '{1, 10, 20, 1'b0, 1'b0, 8'hFF, 1'b0, 72, 96, 12};
    vecs[2] = '{1, 200, 100, 1'b0, 1'b0, 8'h03, 1'b0, 72, 96, 12};
    vecs[3] = '{40, 128, 16, 1'b1, 1'b1, 8'h00, 1'b1, 128, -1, 640};
    vecs[4] = '{40, 236, 316, 1'b1, 1'b0, 8'hA5, 1'b0, 16, 160, 640};
    vecs[5] = '{100, 0, 0, 1'b1, 1'b1, 8'h00, 1'b0, 128, 160, 0};
    vecs[6] = '{94, 236, 312, 1'b0, 1'b1, 8'h00, 1'b0, 32, 96, 1128};
    vecs[7] = '{33, 300, 10, 1'b1, 1'b0, 8'hFF, 1'b0, 0, 160, 528};

    sys_rst = 1'b1; show_char_flag = 1'b0; ascii_num = '0;
    start_x = '0; start_y = '0; en_size = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset_state", {rom_addr, rom_sel, pix_valid, pix_x, pix_y, pix_color, busy, show_char_done}, 0);
    sys_rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      start_char(vecs[k]);
      finish_char(vecs[k]);
    end

    // Flag pulse mid-character must be ignored.
    start_char(vecs[0]);
    repeat (50) @(negedge sys_clk);
    ascii_num = 7'd5; en_size = 1'b0; show_char_flag = 1'b1;
    @(negedge sys_clk);
    show_char_flag = 1'b0; ascii_num = 7'd40; en_size = 1'b1;
    finish_char(vecs[0]);

    // Flag coinciding with the done cycle must be ignored.
    start_char(vecs[0]);
    n = 0;
    while (edge_cnt != req_edge + 160 && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk("done_high_at_160", show_char_done, 1);
    show_char_flag = 1'b1;
    @(negedge sys_clk);
    show_char_flag = 1'b0;
    chk("flag_in_done_ignored", busy, 0);
    finish_char(vecs[0]);

    // Reset in the middle of row 5 aborts without a done pulse.
    start_char(vecs[0]);
    n = 0;
    while (edge_cnt != req_edge + 55 && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk("busy_mid_row5", busy, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_outputs", {rom_addr, rom_sel, pix_valid, pix_x, pix_y, pix_color, busy, show_char_done}, 0);
    sys_rst = 1'b0;
    repeat (200) @(negedge sys_clk);
    chk("no_done_after_abort", done_cnt, 0);
    chk("idle_after_abort", busy, 0);
    start_char(vecs[0]);
    finish_char(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_show_char_engine.md
# lcd_show_char_engine

Character rasteriser directly downstream of the string/number display controller. It accepts one character request per `show_char_flag` pulse: ASCII index, top-left pixel, font size. It fetches the glyph row by row from an external synchronous font ROM and emits one foreground/background colour pixel per column through a valid/ready stream to the LCD pixel writer. On completion it pulses `show_char_done` so the controller can advance to the next character.

## Interface
- `FG_COLOR`, 16'h0000, RGB565 colour for set glyph bits
- `BG_COLOR`, 16'hFFFF, RGB565 colour for clear glyph bits
- `LCD_W`, 240, screen width in pixels; x ≥ LCD_W is clipped
- `LCD_H`, 320, screen height in pixels; y ≥ LCD_H is clipped

Ports:
- `sys_clk`  in  1  single clock; all logic on rising edge
- `sys_rst`  in  1  synchronous, active-high reset
- `show_char_flag`  in  1  one-cycle request strobe
- `ascii_num`  in  7  glyph index = ASCII − 32, valid 0..94
- `start_x`  in  9  glyph left column
- `start_y`  in  9  glyph top row
- `en_size`  in  1  1 = 16x8 font, 0 = 12x6 font
- `rom_addr`  out  11  font ROM address, registered
- `rom_sel`  out  1  ROM bank select, equals latched en_size
- `rom_data`  in  8  glyph row, MSB = leftmost pixel; 1-cycle read latency
- `pix_valid`  out  1  pixel beat valid
- `pix_ready`  in  1  downstream accepts beat
- `pix_x`  out  9  pixel column
- `pix_y`  out  9  pixel row
- `pix_color`  out  16  pixel colour
- `busy`  out  1  high from request accept to done
- `show_char_done`  out  1  one-cycle completion pulse

## Operation
- Geometry: en_size=1 gives ROWS=16, COLS=8, all 8 rom_data bits used. en_size=0 gives ROWS=12, COLS=6, bits [7:2] used and [1:0] ignored.
- Address: `rom_addr = idx*ROWS + row`, 11-bit unsigned. `idx` = ascii_num if ≤ 94, else 0 (space).
- Request accept: only in IDLE. Latch ascii_num, start_x, start_y and en_size; set busy. A flag seen while busy is ignored, with no queuing.
- States:
  - IDLE: waits for flag.
  - ADDR: rom_addr holds the row address; wait one cycle for ROM latency.
  - LOAD: capture rom_data into the row shift register; col=0.
  - PIX: per column, either emit the pixel or skip it; then advance.
  - DONE: pulse show_char_done, clear busy, go to IDLE.
- PIX detail:
  - Pixel coordinates: x = start_x + col and y = start_y + row, computed 10-bit.
  - In range (x < LCD_W and y < LCD_H): assert pix_valid. Advance col only on pix_valid && pix_ready.
  - Out of range: pix_valid stays low and col advances in one cycle.
  - pix_color = FG_COLOR when the current bit is 1, else BG_COLOR.
- Row/character end: after col = COLS−1 advances, go to ADDR with row+1. After row = ROWS−1, go to DONE.
- Outputs are registered. pix_x and pix_y carry the low 9 bits.

## Timing
- Reset values:
  - rom_addr=0, rom_sel=0
  - pix_valid=0, pix_x=0, pix_y=0, pix_color=0
  - busy=0, show_char_done=0
  - state=IDLE
- Reset mid-character aborts immediately to IDLE. No done pulse is issued.
- Request at edge N: busy=1 and rom_addr valid after N. Row data is captured at N+2. First pix_valid is high after N+2.
- Per row with pix_ready=1 and no clipping: 2 fetch cycles + COLS beats. One character therefore takes 160 cycles (16x8) or 96 cycles (12x6). show_char_done is high the cycle after the last beat is accepted, and busy falls on the same edge.
- Handshake: while pix_valid && !pix_ready, pix_x, pix_y and pix_color hold stable. pix_valid never drops without acceptance except on reset.
- show_char_flag coinciding with show_char_done (state DONE) is ignored. It is accepted only in IDLE, one cycle later.
- A fully clipped character still walks all rows and columns, with no pix_valid, then pulses done.

## Test plan
- 16x8 request: ascii_num=40 ('H'), (128,16), pix_ready=1, ROM model returns 8'hA5 on all rows. Expect:
  - rom_addr sequence 640..655.
  - 128 beats, x 128..135 and y 16..31.
  - Colours FG,BG,FG,BG,BG,FG,BG,FG per row.
  - done at cycle 160, single pulse.
- 12x6 request: ascii_num=1 with rom_data=8'hFF. Expect:
  - rom_addr 12..23.
  - 72 beats, all FG_COLOR, bits [1:0] never used.
  - done at cycle 96.
- Backpressure: toggle pix_ready pseudo-randomly. Expect coordinates and colour stable while stalled, no beats lost or duplicated, still 128 beats in raster order.
- Clipping: start_x=236 and start_y=316, 16x8 font. Expect exactly 16 beats (x 236..239, y 316..319), then done.
- Out-of-range and reentry: ascii_num=100 gives rom_addr base 0. A flag pulse mid-character is ignored: beat count is unchanged and exactly one done occurs.
- sys_rst asserted mid-row 5: next cycle all outputs are at reset values and there is no done pulse. A new request afterwards renders normally.
